// File: rtl/ysyx_22040127_wb_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ysyx_22040127_wb_stage_pkg                                       |
// | Brief   : Shared mem-to-wb bus layout, CSR addresses and trap constants.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package ysyx_22040127_wb_stage_pkg;

  // Packed mem-to-wb bus; the first field sits at the MSB end.
  typedef struct packed {
    logic [31:0] instr;
    logic        mmio;
    logic        timer_int;
    logic        ebreak;
    logic        memwrite;
    logic [63:0] diff_data;
    logic [63:0] diff_addr;
    logic [11:0] des_csr;
    logic [63:0] alu_input1;
    logic [4:0]  rs1;
    logic        csr_we;
    logic        mret;
    logic        ecall;
    logic        csrrw;
    logic        csrrs;
    logic        csrrc;
    logic        csrrwi;
    logic        csrrsi;
    logic        csrrci;
    logic [31:0] pc;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] reg_wdata;
  } mem_to_wb_t;

  localparam int MEM_TO_WB_WIDTH = $bits(mem_to_wb_t);

  localparam logic [11:0] c_csr_mstatus  = 12'h300;
  localparam logic [11:0] c_csr_mtvec    = 12'h305;
  localparam logic [11:0] c_csr_mepc     = 12'h341;
  localparam logic [11:0] c_csr_mcause   = 12'h342;
  localparam logic [11:0] c_csr_minstret = 12'hB02;

  localparam int c_mstatus_mie  = 3;
  localparam int c_mstatus_mpie = 7;

  localparam logic [63:0] c_mstatus_reset = 64'h0000_000A_0000_1800;
  localparam logic [63:0] c_mcause_ecall  = 64'd11;
  localparam logic [63:0] c_mcause_timer  = 64'h8000_0000_0000_0007;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_e;

  function automatic logic [63:0] csr_apply(input csr_op_e op, input logic [63:0] old_val,
                                            input logic [63:0] operand);
    logic [63:0] r;
    case (op)
      CSR_OP_RW: r = operand;
      CSR_OP_RS: r = old_val | operand;
      CSR_OP_RC: r = old_val & ~operand;
      default:   r = old_val;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040127_wb_stage_csr_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ysyx_22040127_csr_file                                           |
// | Brief   : Machine-mode CSRs with rw/rs/rc update and trap/mret effects.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ysyx_22040127_csr_file
  import ysyx_22040127_wb_stage_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  csr_op_e         csr_op,
  input  logic [XLEN-1:0] csr_operand,
  input  logic            ecall,
  input  logic            mret,
  input  logic            timer_int,
  input  logic [PC_W-1:0] pc,
  output logic [XLEN-1:0] csr_rdata,
  output logic [PC_W-1:0] trap_vec,
  output logic [PC_W-1:0] epc,
  output logic [63:0]     minstret
);

  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [63:0]     r_minstret;

  logic            w_trap;
  logic            w_mret;
  logic            w_csr_wr;
  logic            w_retire;
  logic [XLEN-1:0] w_new_val;

  // Priority: timer interrupt > ecall > mret > plain CSR write.
  assign w_trap   = valid & (timer_int | ecall);
  assign w_mret   = valid & mret & ~timer_int & ~ecall;
  assign w_csr_wr = valid & csr_we & ~timer_int & ~ecall & ~mret;
  assign w_retire = valid & ~timer_int;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      c_csr_mstatus:  csr_rdata = r_mstatus;
      c_csr_mtvec:    csr_rdata = r_mtvec;
      c_csr_mepc:     csr_rdata = r_mepc;
      c_csr_mcause:   csr_rdata = r_mcause;
      c_csr_minstret: csr_rdata = XLEN'(r_minstret);
      default:        csr_rdata = '0;
    endcase
  end

  assign w_new_val = XLEN'(csr_apply(csr_op, 64'(csr_rdata), 64'(csr_operand)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mstatus <= XLEN'(c_mstatus_reset);
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else if (w_trap) begin
      r_mepc                    <= XLEN'(pc);
      r_mcause                  <= timer_int ? XLEN'(c_mcause_timer) : XLEN'(c_mcause_ecall);
      r_mstatus[c_mstatus_mpie] <= r_mstatus[c_mstatus_mie];
      r_mstatus[c_mstatus_mie]  <= 1'b0;
    end else if (w_mret) begin
      r_mstatus[c_mstatus_mie]  <= r_mstatus[c_mstatus_mpie];
      r_mstatus[c_mstatus_mpie] <= 1'b1;
    end else if (w_csr_wr) begin
      case (csr_addr)
        c_csr_mstatus: r_mstatus <= w_new_val;
        c_csr_mtvec:   r_mtvec   <= w_new_val;
        c_csr_mepc:    r_mepc    <= w_new_val;
        c_csr_mcause:  r_mcause  <= w_new_val;
        default:       ;
      endcase
    end
  end

  // An explicit write to minstret wins over the retire increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_minstret <= '0;
    end else if (w_csr_wr && (csr_addr == c_csr_minstret)) begin
      r_minstret <= 64'(w_new_val);
    end else if (w_retire) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end

  assign trap_vec = r_mtvec[PC_W-1:0];
  assign epc      = r_mepc[PC_W-1:0];
  assign minstret = r_minstret;

endmodule
`default_nettype wire

// File: rtl/ysyx_22040127_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ysyx_22040127_wb_stage                                           |
// | Brief   : RV64 write-back stage: regfile write, M-mode CSRs, trap redirect.|
// |           Optional DIFFTEST_EN adds registered commit-trace outputs.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ysyx_22040127_wb_stage
  import ysyx_22040127_wb_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int BUS_W = MEM_TO_WB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_to_wb_valid,
  output logic             wb_allowin,
  input  logic [BUS_W-1:0] mem_to_wb_bus,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [4:0]       wb_rd_fwd,
  output logic             wb_flush,
  output logic [PC_W-1:0]  wb_flush_pc,
  output logic             halt,
  output logic [63:0]      minstret
`ifdef DIFFTEST_EN
  ,
  output logic             commit_valid,
  output logic [PC_W-1:0]  commit_pc,
  output logic [31:0]      commit_instr,
  output logic             commit_skip,
  output logic [XLEN-1:0]  commit_mem_addr,
  output logic [XLEN-1:0]  commit_mem_data
`endif
);

  logic            r_wb_valid;
  logic            r_halt;
  mem_to_wb_t      r_bus;

  logic            w_valid;
  logic            w_is_csr;
  logic            w_is_imm;
  csr_op_e         w_csr_op;
  logic [XLEN-1:0] w_operand;
  logic [XLEN-1:0] w_csr_rdata;
  logic [PC_W-1:0] w_trap_vec;
  logic [PC_W-1:0] w_epc;

  // Ready-go is always 1, so the stage only stalls once halted.
  assign wb_allowin = ~(r_halt & rst_n);

  always_ff @(posedge clk) begin
    if (!rst_n || r_halt) begin
      r_wb_valid <= 1'b0;
    end else if (wb_allowin) begin
      r_wb_valid <= mem_to_wb_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_to_wb_valid && wb_allowin) begin
      r_bus <= mem_to_wb_t'(mem_to_wb_bus);
    end
  end

  // Reset or halt squashes whatever is sitting in the stage.
  assign w_valid = r_wb_valid & rst_n & ~r_halt;

  assign w_is_imm = r_bus.csrrwi | r_bus.csrrsi | r_bus.csrrci;
  assign w_is_csr = w_is_imm | r_bus.csrrw | r_bus.csrrs | r_bus.csrrc;
  assign w_operand = w_is_imm ? XLEN'(r_bus.rs1) : XLEN'(r_bus.alu_input1);

  always_comb begin
    w_csr_op = CSR_OP_NONE;
    if (r_bus.csrrw | r_bus.csrrwi)      w_csr_op = CSR_OP_RW;
    else if (r_bus.csrrs | r_bus.csrrsi) w_csr_op = CSR_OP_RS;
    else if (r_bus.csrrc | r_bus.csrrci) w_csr_op = CSR_OP_RC;
  end

  ysyx_22040127_csr_file #(
    .XLEN (XLEN),
    .PC_W (PC_W)
  ) u_csr_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (w_valid),
    .csr_we      (r_bus.csr_we),
    .csr_addr    (r_bus.des_csr),
    .csr_op      (w_csr_op),
    .csr_operand (w_operand),
    .ecall       (r_bus.ecall),
    .mret        (r_bus.mret),
    .timer_int   (r_bus.timer_int),
    .pc          (r_bus.pc[PC_W-1:0]),
    .csr_rdata   (w_csr_rdata),
    .trap_vec    (w_trap_vec),
    .epc         (w_epc),
    .minstret    (minstret)
  );

  assign rf_we     = w_valid & r_bus.reg_wen & (r_bus.rd != 5'd0) & ~r_bus.timer_int;
  assign rf_waddr  = w_valid ? r_bus.rd : 5'd0;
  assign rf_wdata  = !w_valid ? '0 : (w_is_csr ? w_csr_rdata : XLEN'(r_bus.reg_wdata));
  assign wb_rd_fwd = (w_valid & r_bus.reg_wen) ? r_bus.rd : 5'd0;

  assign wb_flush = w_valid & (r_bus.timer_int | r_bus.ecall | r_bus.mret);

  always_comb begin
    wb_flush_pc = '0;
    if (w_valid) begin
      if (r_bus.timer_int | r_bus.ecall) wb_flush_pc = w_trap_vec;
      else if (r_bus.mret)               wb_flush_pc = w_epc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_halt <= 1'b0;
    end else if (w_valid && r_bus.ebreak && !r_bus.timer_int) begin
      r_halt <= 1'b1;
    end
  end

  assign halt = r_halt;

`ifdef DIFFTEST_EN
  // Trace lags commit by one cycle so the regfile already holds the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_valid    <= 1'b0;
      commit_pc       <= '0;
      commit_instr    <= '0;
      commit_skip     <= 1'b0;
      commit_mem_addr <= '0;
      commit_mem_data <= '0;
    end else begin
      commit_valid    <= w_valid & ~r_bus.timer_int;
      commit_pc       <= r_bus.pc[PC_W-1:0];
      commit_instr    <= r_bus.instr;
      commit_skip     <= r_bus.mmio;
      commit_mem_addr <= r_bus.memwrite ? XLEN'(r_bus.diff_addr) : '0;
      commit_mem_data <= r_bus.memwrite ? XLEN'(r_bus.diff_data) : '0;
    end
  end
`else
  logic w_unused_bus;
  assign w_unused_bus = ^{r_bus.instr, r_bus.mmio, r_bus.memwrite, r_bus.diff_data,
                          r_bus.diff_addr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ysyx_22040127_wb_stage                                        |
// | Brief   : Directed self-checking bench for the write-back stage.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ysyx_22040127_wb_stage;
  import ysyx_22040127_wb_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_to_wb_valid;
  logic        wb_allowin;
  mem_to_wb_t  mem_to_wb_bus;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  wb_rd_fwd;
  logic        wb_flush;
  logic [31:0] wb_flush_pc;
  logic        halt;
  logic [63:0] minstret;
`ifdef DIFFTEST_EN
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_instr;
  logic        commit_skip;
  logic [63:0] commit_mem_addr;
  logic [63:0] commit_mem_data;
`endif

  int total = 0;
  int bad   = 0;

  // Expected minstret, advanced as each held instruction commits.
  logic [63:0] exp_ret      = '0;
  bit          held_commit  = 1'b0;
  bit          held_wr_ret  = 1'b0;
  logic [63:0] held_ret_val = '0;

  ysyx_22040127_wb_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_to_wb_valid (mem_to_wb_valid),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .wb_rd_fwd       (wb_rd_fwd),
    .wb_flush        (wb_flush),
    .wb_flush_pc     (wb_flush_pc),
    .halt            (halt),
    .minstret        (minstret)
`ifdef DIFFTEST_EN
    ,
    .commit_valid    (commit_valid),
    .commit_pc       (commit_pc),
    .commit_instr    (commit_instr),
    .commit_skip     (commit_skip),
    .commit_mem_addr (commit_mem_addr),
    .commit_mem_data (commit_mem_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic mem_to_wb_t f_alu(input logic [4:0] rd, input logic [63:0] wdata);
    mem_to_wb_t b = '0;
    b.reg_wen   = 1'b1;
    b.rd        = rd;
    b.reg_wdata = wdata;
    b.pc        = 32'h8000_0000;
    return b;
  endfunction

  // op: 0 = rw, 1 = rs, 2 = rc; result goes to x1.
  function automatic mem_to_wb_t f_csr(input logic [11:0] addr, input int op, input bit imm,
                                       input bit we, input logic [63:0] opnd);
    mem_to_wb_t b = '0;
    b.des_csr = addr;
    b.csr_we  = we;
    b.reg_wen = 1'b1;
    b.rd      = 5'd1;
    b.pc      = 32'h8000_0000;
    if (imm) b.rs1 = opnd[4:0];
    else     b.alu_input1 = opnd;
    if (op == 0) begin b.csrrw = !imm; b.csrrwi = imm; end
    else if (op == 1) begin b.csrrs = !imm; b.csrrsi = imm; end
    else begin b.csrrc = !imm; b.csrrci = imm; end
    return b;
  endfunction

  function automatic mem_to_wb_t f_sys(input bit ecall, input bit mret, input bit timer,
                                       input bit ebreak, input logic [31:0] pc);
    mem_to_wb_t b = '0;
    b.ecall     = ecall;
    b.mret      = mret;
    b.timer_int = timer;
    b.ebreak    = ebreak;
    b.pc        = pc;
    return b;
  endfunction

  // Present one instruction for one edge; afterwards it sits in wb.
  task automatic step(input mem_to_wb_t b, input logic v);
    mem_to_wb_valid = v;
    mem_to_wb_bus   = b;
    @(posedge clk);
    #1;
    if (held_wr_ret)      exp_ret = held_ret_val;
    else if (held_commit) exp_ret = exp_ret + 64'd1;
    held_commit  = v && !b.timer_int;
    held_wr_ret  = v && b.csr_we && (b.des_csr == 12'hB02) && !b.timer_int && !b.ecall && !b.mret;
    held_ret_val = b.alu_input1;
    mem_to_wb_valid = 1'b0;
  endtask

  mem_to_wb_t b;

  initial begin
    rst_n = 1'b0;
    mem_to_wb_valid = 1'b0;
    mem_to_wb_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_allowin", 64'(wb_allowin), 64'd1);
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_halt", 64'(halt), 64'd0);
    chk("reset_minstret", minstret, 64'd0);
    chk("reset_flush", 64'(wb_flush), 64'd0);
    rst_n = 1'b1;

    // Back-to-back ALU results, second one to x0.
    step(f_alu(5'd5, 64'h1234), 1'b1);
    chk("addi_we", 64'(rf_we), 64'd1);
    chk("addi_waddr", 64'(rf_waddr), 64'd5);
    chk("addi_wdata", rf_wdata, 64'h1234);
    chk("addi_fwd", 64'(wb_rd_fwd), 64'd5);
    step(f_alu(5'd0, 64'h55), 1'b1);
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_minstret", minstret, 64'd1);

    // csrrw mtvec then ecall.
    step(f_csr(12'h305, 0, 1'b0, 1'b1, 64'h8000_0100), 1'b1);
    chk("csrrw_old_mtvec", rf_wdata, 64'd0);
    chk("csrrw_minstret", minstret, 64'd2);
    step(f_sys(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0040), 1'b1);
    chk("ecall_flush", 64'(wb_flush), 64'd1);
    chk("ecall_flush_pc", 64'(wb_flush_pc), 64'h8000_0100);
    chk("ecall_rf_we", 64'(rf_we), 64'd0);
    step(f_csr(12'h341, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("mepc_after_ecall", rf_wdata, 64'h8000_0040);
    chk("flush_one_cycle", 64'(wb_flush), 64'd0);
    step(f_csr(12'h342, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("mcause_ecall", rf_wdata, 64'd11);
    step(f_csr(12'h300, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("mstatus_after_ecall", rf_wdata, 64'h0000_000A_0000_1800);

    // csrrsi sets MIE, ecall moves it to MPIE, mret restores it.
    step(f_csr(12'h300, 1, 1'b1, 1'b1, 64'd8), 1'b1);
    chk("csrrsi_old", rf_wdata, 64'h0000_000A_0000_1800);
    step(f_csr(12'h300, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("mstatus_mie_set", rf_wdata, 64'h0000_000A_0000_1808);
    step(f_sys(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0080), 1'b1);
    chk("ecall2_flush_pc", 64'(wb_flush_pc), 64'h8000_0100);
    step(f_csr(12'h300, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("mstatus_ecall2", rf_wdata, 64'h0000_000A_0000_1880);
    step(f_sys(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0300), 1'b1);
    chk("mret_flush", 64'(wb_flush), 64'd1);
    chk("mret_flush_pc", 64'(wb_flush_pc), 64'h8000_0080);
    step(f_csr(12'h300, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("mstatus_mret", rf_wdata, 64'h0000_000A_0000_1888);
    step(f_csr(12'h300, 2, 1'b1, 1'b1, 64'd8), 1'b1);
    chk("csrrci_old", rf_wdata, 64'h0000_000A_0000_1888);
    step(f_csr(12'h300, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("mstatus_csrrci", rf_wdata, 64'h0000_000A_0000_1880);

    // Timer interrupt on an instruction that would write x7.
    b = f_sys(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0200);
    b.reg_wen = 1'b1;
    b.rd = 5'd7;
    b.reg_wdata = 64'h77;
    step(b, 1'b1);
    chk("timer_rf_we", 64'(rf_we), 64'd0);
    chk("timer_flush", 64'(wb_flush), 64'd1);
    chk("timer_flush_pc", 64'(wb_flush_pc), 64'h8000_0100);
    step(f_csr(12'h342, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("timer_mcause", rf_wdata, 64'h8000_0000_0000_0007);
    chk("timer_minstret", minstret, exp_ret);
    step(f_csr(12'h341, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("timer_mepc", rf_wdata, 64'h8000_0200);

    // minstret preset to all ones, then wrap.
    step(f_csr(12'hB02, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF), 1'b1);
    step(f_alu(5'd2, 64'd2), 1'b1);
    chk("minstret_preset", minstret, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("minstret_model", exp_ret, 64'hFFFF_FFFF_FFFF_FFFF);
    step(f_alu(5'd2, 64'd3), 1'b1);
    chk("minstret_wrap", minstret, 64'd0);

    // Unknown CSR reads zero and ignores writes.
    step(f_csr(12'h7C0, 0, 1'b0, 1'b1, 64'd5), 1'b1);
    chk("unknown_csr_old", rf_wdata, 64'd0);
    step(f_csr(12'h7C0, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("unknown_csr_read", rf_wdata, 64'd0);

    // ebreak halts and stalls the stage until reset.
    step(f_sys(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0400), 1'b1);
    chk("ebreak_pre_halt", 64'(halt), 64'd0);
    step(f_alu(5'd4, 64'h44), 1'b1);
    chk("halt_set", 64'(halt), 64'd1);
    chk("halt_allowin", 64'(wb_allowin), 64'd0);
    chk("halt_rf_we", 64'(rf_we), 64'd0);
    step(f_alu(5'd4, 64'h45), 1'b1);
    chk("halt_sticky", 64'(halt), 64'd1);
    chk("halt_rf_we2", 64'(rf_we), 64'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_allowin", 64'(wb_allowin), 64'd1);
    chk("rst_minstret", minstret, 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    step(f_csr(12'h300, 1, 1'b0, 1'b0, 64'd0), 1'b1);
    chk("rst_mstatus", rf_wdata, 64'h0000_000A_0000_1800);

    // Reset arriving while an instruction is in wb drops it.
    step(f_alu(5'd9, 64'h99), 1'b1);
    chk("inflight_we", 64'(rf_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("inflight_rst_we", 64'(rf_we), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("inflight_after_we", 64'(rf_we), 64'd0);
    chk("inflight_minstret", minstret, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
